instr_sequencer: RTL and testbench

Multi-cycle fetch/decode sequencer that sits directly upstream of the processor register file. It does four things:
- fetches 32-bit instruction words from instruction memory over a request/valid handshake;
- decodes the register fields and drives the register file's address, read-strobe and write-enable controls;
- sequences one instruction at a time through fixed states;
- owns the program counter and mirrors it into the register file's PC slot at write-back.

---
 rtl/instr_sequencer.sv | 144 ++++++++++++++
 tb/tb_instr_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer
// Multi-cycle fetch/decode sequencer in front of the register file. It fetches
// one 32-bit word at a time over a request/valid handshake, decodes the
// register fields, walks the instruction through fixed states and owns the PC.
// The PC is mirrored into the register file's PC slot at write-back.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   instrReq/instrAddr  fetch request and address (instrAddr is the current PC)
//   instrIn/instrValid  fetched word and its valid, sampled only in FETCH
//   enable              register file write enable (WB only)
//   addressA/B/Result   ra / rb / rd fields of the latched instruction
//   rwA, rwB            tied 0 (operands are only ever read)
//   rwResult            destination write strobe (WB, writing opcodes only)
//   rwPc, dataInPc      PC slot write strobe and next-PC value (WB)
//   getPc               PC slot read strobe (READ)
//   Aout                operand A from the register file, used by BEQZ
//   aluOp, immOut       opcode and sign-extended immediate
//   halted              set once HALT is decoded; cleared only by reset
module instr_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        instrReq,
    output logic [31:0] instrAddr,
    input  logic [31:0] instrIn,
    input  logic        instrValid,
    output logic        enable,
    output logic [3:0]  addressA,
    output logic [3:0]  addressB,
    output logic [3:0]  addressResult,
    output logic        rwA,
    output logic        rwB,
    output logic        rwResult,
    output logic        rwPc,
    output logic [31:0] dataInPc,
    output logic        getPc,
    input  logic [31:0] Aout,
    output logic [3:0]  aluOp,
    output logic [31:0] immOut,
    output logic        halted
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, READ, EXEC, WB, HALT
    } state_t;

    localparam logic [3:0] OP_LAST_WRITE = 4'h8;
    localparam logic [3:0] OP_BEQZ       = 4'hC;
    localparam logic [3:0] OP_HALT       = 4'hF;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;
    logic        writes_rd;

    assign rwA       = 1'b0;
    assign rwB       = 1'b0;
    assign instrAddr = pc;

    // The decoded field registers double as the instruction register: every
    // bit the sequencer ever uses lives in one of them. The branch offset is
    // the sign-extended immediate in words, hence the shift by 2.
    assign seq_pc    = pc + PC_STEP;
    assign next_pc   = (aluOp == OP_BEQZ && Aout == 32'd0) ? seq_pc + (immOut << 2) : seq_pc;
    assign writes_rd = (aluOp <= OP_LAST_WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            instrReq      <= 1'b0;
            enable        <= 1'b0;
            rwResult      <= 1'b0;
            rwPc          <= 1'b0;
            getPc         <= 1'b0;
            halted        <= 1'b0;
            dataInPc      <= 32'd0;
            addressA      <= 4'd0;
            addressB      <= 4'd0;
            addressResult <= 4'd0;
            aluOp         <= 4'd0;
            immOut        <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    instrReq <= 1'b1;
                    state    <= FETCH;
                end
                FETCH: begin
                    // No timeout: memory may stall indefinitely.
                    if (instrValid) begin
                        aluOp         <= instrIn[31:28];
                        addressResult <= instrIn[27:24];
                        addressA      <= instrIn[23:20];
                        addressB      <= instrIn[19:16];
                        immOut        <= {{16{instrIn[15]}}, instrIn[15:0]};
                        instrReq      <= 1'b0;
                        state         <= DECODE;
                    end
                end
                DECODE: begin
                    if (aluOp == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        getPc  <= 1'b1;
                        state  <= READ;
                    end
                end
                READ: begin
                    getPc <= 1'b0;
                    state <= EXEC;
                end
                EXEC: begin
                    // Aout is sampled here, at the edge closing EXEC.
                    enable   <= 1'b1;
                    rwPc     <= 1'b1;
                    rwResult <= writes_rd;
                    dataInPc <= next_pc;
                    state    <= WB;
                end
                WB: begin
                    enable   <= 1'b0;
                    rwPc     <= 1'b0;
                    rwResult <= 1'b0;
                    pc       <= dataInPc;
                    instrReq <= 1'b1;
                    state    <= FETCH;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: reset, basic write, fetch stall, BEQZ
// taken / not taken / wrap, HALT, and reset during write-back.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instrReq;
    logic [31:0] instrAddr;
    logic [31:0] instrIn = 32'd0;
    logic        instrValid = 1'b0;
    logic        enable;
    logic [3:0]  addressA, addressB, addressResult;
    logic        rwA, rwB, rwResult, rwPc, getPc, halted;
    logic [31:0] dataInPc;
    logic [31:0] Aout = 32'd0;
    logic [3:0]  aluOp;
    logic [31:0] immOut;

    int n_chk  = 0;
    int n_fail = 0;

    instr_sequencer dut (
        .clk(clk), .rst(rst),
        .instrReq(instrReq), .instrAddr(instrAddr),
        .instrIn(instrIn), .instrValid(instrValid),
        .enable(enable),
        .addressA(addressA), .addressB(addressB), .addressResult(addressResult),
        .rwA(rwA), .rwB(rwB), .rwResult(rwResult), .rwPc(rwPc),
        .dataInPc(dataInPc), .getPc(getPc), .Aout(Aout),
        .aluOp(aluOp), .immOut(immOut), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Reset, release, and step into the first FETCH cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        instrValid = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    // From a FETCH cycle: present one instruction, run to WB (bounded), report
    // WB outputs, then step back into FETCH.
    task automatic run_instr(input logic [31:0] instr, input logic [31:0] a,
                             output logic ok, output logic [31:0] dpc,
                             output logic rwr);
        instrIn    = instr;
        instrValid = 1'b1;
        Aout       = a;
        ok  = 1'b0;
        dpc = 32'hx;
        rwr = 1'bx;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick(1);
            instrValid = 1'b0;
            if (enable === 1'b1) begin
                ok  = 1'b1;
                dpc = dataInPc;
                rwr = rwResult;
            end
        end
        tick(1);
    endtask

    task automatic test_reset();
        #1;
        n_chk++; if (instrReq !== 1'b0) begin n_fail++; $display("FAIL rst_instrReq got %b want 0", instrReq); end
        n_chk++; if (instrAddr !== 32'h0) begin n_fail++; $display("FAIL rst_instrAddr got %h want 0", instrAddr); end
        n_chk++; if ({enable, rwResult, rwPc, getPc, halted, rwA, rwB} !== 7'b0) begin n_fail++; $display("FAIL rst_strobes got %b want 0", {enable, rwResult, rwPc, getPc, halted, rwA, rwB}); end
        n_chk++; if ({addressA, addressB, addressResult, aluOp, immOut, dataInPc} !== 80'h0) begin n_fail++; $display("FAIL rst_fields got %h want 0", {addressA, addressB, addressResult, aluOp, immOut, dataInPc}); end
        instrIn    = 32'h1321_0000;
        instrValid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        // First cycle after release is IDLE.
        n_chk++; if (instrReq !== 1'b0) begin n_fail++; $display("FAIL idle_instrReq got %b want 0", instrReq); end
        tick(1);
        n_chk++; if (instrReq !== 1'b1) begin n_fail++; $display("FAIL fetch_instrReq got %b want 1", instrReq); end
    endtask

    task automatic test_basic_write();
        tick(1); // DECODE
        n_chk++; if ({addressResult, addressA, addressB} !== 12'h321) begin n_fail++; $display("FAIL dec_addr got %h want 321", {addressResult, addressA, addressB}); end
        n_chk++; if (instrReq !== 1'b0) begin n_fail++; $display("FAIL dec_instrReq got %b want 0", instrReq); end
        instrValid = 1'b0;
        tick(1); // READ
        n_chk++; if (getPc !== 1'b1) begin n_fail++; $display("FAIL read_getPc got %b want 1", getPc); end
        tick(1); // EXEC
        n_chk++; if ({getPc, enable} !== 2'b00) begin n_fail++; $display("FAIL exec_strobes got %b want 00", {getPc, enable}); end
        n_chk++; if (aluOp !== 4'h1) begin n_fail++; $display("FAIL exec_aluOp got %h want 1", aluOp); end
        tick(1); // WB
        n_chk++; if ({enable, rwResult, rwPc} !== 3'b111) begin n_fail++; $display("FAIL wb_strobes got %b want 111", {enable, rwResult, rwPc}); end
        n_chk++; if ({addressResult, addressA, addressB} !== 12'h321) begin n_fail++; $display("FAIL wb_addr got %h want 321", {addressResult, addressA, addressB}); end
        n_chk++; if (dataInPc !== 32'h4) begin n_fail++; $display("FAIL wb_dataInPc got %h want 4", dataInPc); end
        tick(1); // FETCH
        n_chk++; if ({instrReq, enable, rwResult, rwPc} !== 4'b1000) begin n_fail++; $display("FAIL post_wb_strobes got %b want 1000", {instrReq, enable, rwResult, rwPc}); end
        n_chk++; if (instrAddr !== 32'h4) begin n_fail++; $display("FAIL post_wb_addr got %h want 4", instrAddr); end
    endtask

    task automatic test_fetch_stall();
        int cyc;
        do_reset();
        instrIn = 32'h9000_0000;
        for (int i = 0; i < 3; i++) begin
            n_chk++; if ({instrReq, instrAddr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL stall_req got %b/%h want 1/0", instrReq, instrAddr); end
            tick(1);
        end
        instrValid = 1'b1;
        cyc = 3;
        while (enable !== 1'b1 && cyc < 30) begin
            tick(1);
            instrValid = 1'b0;
            cyc++;
        end
        n_chk++; if (cyc !== 7) begin n_fail++; $display("FAIL stall_latency got %0d want 7", cyc); end
        n_chk++; if ({rwResult, rwPc} !== 2'b01) begin n_fail++; $display("FAIL stall_nop_strobes got %b want 01", {rwResult, rwPc}); end
        tick(1);
        n_chk++; if (instrAddr !== 32'h4) begin n_fail++; $display("FAIL stall_pc got %h want 4", instrAddr); end
    endtask

    task automatic test_beqz();
        logic ok, rwr;
        logic [31:0] dpc;
        // Taken at PC=0x10.
        do_reset();
        for (int i = 0; i < 4; i++) run_instr(32'h9000_0000, 32'd0, ok, dpc, rwr);
        n_chk++; if (instrAddr !== 32'h10) begin n_fail++; $display("FAIL beqz_setup_pc got %h want 10", instrAddr); end
        run_instr(32'hC010_0003, 32'd0, ok, dpc, rwr);
        n_chk++; if ({ok, rwr, dpc} !== {2'b10, 32'h20}) begin n_fail++; $display("FAIL beqz_taken got %b%b/%h want 10/20", ok, rwr, dpc); end
        n_chk++; if (instrAddr !== 32'h20) begin n_fail++; $display("FAIL beqz_taken_pc got %h want 20", instrAddr); end
        // Not taken at PC=0x10.
        do_reset();
        for (int i = 0; i < 4; i++) run_instr(32'h9000_0000, 32'd0, ok, dpc, rwr);
        run_instr(32'hC010_0003, 32'd5, ok, dpc, rwr);
        n_chk++; if ({ok, rwr, dpc} !== {2'b10, 32'h14}) begin n_fail++; $display("FAIL beqz_not_taken got %b%b/%h want 10/14", ok, rwr, dpc); end
        // Negative offset at PC=0: 0 + 4 - 4.
        do_reset();
        run_instr(32'hC010_FFFF, 32'd0, ok, dpc, rwr);
        n_chk++; if ({ok, dpc} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL beqz_back got %b/%h want 1/0", ok, dpc); end
        n_chk++; if (immOut !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL beqz_sext got %h want ffffffff", immOut); end
        // Backward branch across zero wraps silently: 0 + 4 - 8.
        run_instr(32'hC010_FFFE, 32'd0, ok, dpc, rwr);
        n_chk++; if (dpc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL beqz_wrap got %h want fffffffc", dpc); end
    endtask

    task automatic test_halt();
        logic ok, rwr;
        logic [31:0] dpc;
        int en_seen;
        do_reset();
        run_instr(32'h9000_0000, 32'd0, ok, dpc, rwr);
        instrIn    = 32'hF000_0000;
        instrValid = 1'b1;
        tick(1); // DECODE
        n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_early got %b want 0", halted); end
        tick(1); // HALT
        n_chk++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag got %b want 1", halted); end
        en_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if ({enable, rwResult, rwPc, getPc, instrReq} !== 5'b0) en_seen++;
            if (instrAddr !== 32'h4) en_seen++;
            tick(1);
        end
        n_chk++; if (en_seen !== 0) begin n_fail++; $display("FAIL halt_quiet got %0d bad cycles want 0", en_seen); end
        rst = 1'b1;
        #1;
        n_chk++; if ({halted, instrAddr} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL halt_rst got %b/%h want 0/0", halted, instrAddr); end
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        n_chk++; if ({instrReq, instrAddr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL halt_refetch got %b/%h want 1/0", instrReq, instrAddr); end
        instrValid = 1'b0;
    endtask

    task automatic test_rst_in_wb();
        int bad;
        do_reset();
        run_instr(32'h9000_0000, 32'd0, bad[0], bad, bad[0]); // advance PC to 4
        instrIn    = 32'h1321_0000;
        instrValid = 1'b1;
        tick(1);
        instrValid = 1'b0;
        tick(3); // WB
        n_chk++; if ({enable, rwResult, instrAddr} !== {2'b11, 32'h4}) begin n_fail++; $display("FAIL rwb_pre got %b%b/%h want 11/4", enable, rwResult, instrAddr); end
        rst = 1'b1;
        #1;
        n_chk++; if ({enable, rwResult, rwPc, instrAddr} !== {3'b000, 32'h0}) begin n_fail++; $display("FAIL rwb_drop got %b/%h want 000/0", {enable, rwResult, rwPc}, instrAddr); end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if ({enable, rwResult, rwPc} !== 3'b000 || instrAddr !== 32'h0) bad++;
        end
        n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL rwb_after got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_fetch_stall();
        test_beqz();
        test_halt();
        test_rst_in_wb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
